// File: rtl/servant_spi_arbiter.sv
// Two-port Wishbone arbiter (ibus read-only, dbus read/write) in front of the SPI FRAM master.
// Latency: grant one cycle after request; upstream ack is combinational from i_spi_ack; writes add WREN + gap.
// Backpressure: requesters hold cyc until ack; downstream cyc drops for >=1 cycle between transactions.
// Build option: define SERVANT_SPI_ARB_RR_EN for round-robin on contention (default: dbus has fixed priority).
module servant_spi_arbiter #(
  parameter int ADDRESS_WIDTH = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:2] i_ibus_adr,
  input  logic                     i_ibus_cyc,
  output logic [31:0]              o_ibus_rdt,
  output logic                     o_ibus_ack,
  input  logic [ADDRESS_WIDTH-1:2] i_dbus_adr,
  input  logic [31:0]              i_dbus_dat,
  input  logic [3:0]               i_dbus_sel,
  input  logic                     i_dbus_we,
  input  logic                     i_dbus_cyc,
  output logic [31:0]              o_dbus_rdt,
  output logic                     o_dbus_ack,
  output logic [ADDRESS_WIDTH-1:2] o_spi_adr,
  output logic [31:0]              o_spi_dat,
  output logic [3:0]               o_spi_sel,
  output logic                     o_spi_we,
  output logic                     o_spi_cyc,
  input  logic [31:0]              i_spi_rdt,
  input  logic                     i_spi_ack
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IBUS = 3'd1,
    S_WREN = 3'd2,
    S_WGAP = 3'd3,
    S_DBUS = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_last_grant;  // 0 = ibus, 1 = dbus
  logic [ADDRESS_WIDTH-1:2] r_adr;
  logic [31:0]              r_dat;
  logic [3:0]               r_sel;
  logic                     r_we;
  logic                     w_grant_i;
  logic                     w_grant_d;

  // Pick at most one requester while idle
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (r_state == S_IDLE) begin
`ifdef SERVANT_SPI_ARB_RR_EN
      if (i_ibus_cyc && i_dbus_cyc) begin
        // Contention: the port that did not win last time goes now
        w_grant_d = ~r_last_grant;
        w_grant_i = r_last_grant;
      end else begin
        w_grant_d = i_dbus_cyc;
        w_grant_i = i_ibus_cyc;
      end
`else
      w_grant_d = i_dbus_cyc;
      w_grant_i = i_ibus_cyc & ~i_dbus_cyc;
`endif
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          // Byte-enabled writes need a FRAM WRITE ENABLE first
          w_next = (i_dbus_we && (i_dbus_sel != 4'h0)) ? S_WREN : S_DBUS;
        end else if (w_grant_i) begin
          w_next = S_IBUS;
        end
      end
      S_IBUS:  if (i_spi_ack) w_next = S_IDLE;
      S_WREN:  if (i_spi_ack) w_next = S_WGAP;
      S_WGAP:  w_next = S_DBUS;
      S_DBUS:  if (i_spi_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: downstream fields come only from latched registers; upstream ack is pass-through
  always_comb begin
    o_spi_cyc  = 1'b0;
    o_spi_we   = r_we;
    o_spi_sel  = r_sel;
    o_spi_adr  = r_adr;
    o_spi_dat  = r_dat;
    o_ibus_ack = 1'b0;
    o_dbus_ack = 1'b0;
    o_ibus_rdt = 32'h0;
    o_dbus_rdt = 32'h0;
    unique case (r_state)
      S_IBUS: begin
        o_spi_cyc  = 1'b1;
        o_ibus_ack = i_spi_ack & i_ibus_cyc;
      end
      S_WREN: begin
        o_spi_cyc = 1'b1;
        o_spi_we  = 1'b1;
        o_spi_sel = 4'h0;
      end
      S_DBUS: begin
        o_spi_cyc  = 1'b1;
        o_dbus_ack = i_spi_ack & i_dbus_cyc;
      end
      default: begin
        o_spi_cyc = 1'b0;
      end
    endcase
    if (o_ibus_ack) o_ibus_rdt = i_spi_rdt;
    if (o_dbus_ack) o_dbus_rdt = i_spi_rdt;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Latch the granted request so later upstream changes cannot leak downstream
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b0;
      r_adr        <= '0;
      r_dat        <= 32'h0;
      r_sel        <= 4'h0;
      r_we         <= 1'b0;
    end else if (w_grant_d) begin
      r_last_grant <= 1'b1;
      r_adr        <= i_dbus_adr;
      r_dat        <= i_dbus_dat;
      r_sel        <= i_dbus_sel;
      r_we         <= i_dbus_we;
    end else if (w_grant_i) begin
      r_last_grant <= 1'b0;
      r_adr        <= i_ibus_adr;
      r_dat        <= 32'h0;
      r_sel        <= 4'hF;
      r_we         <= 1'b0;
    end
  end

endmodule

// File: doc/servant_spi_arbiter.md
# servant_spi_arbiter

Two-port Wishbone arbiter in front of the SPI FRAM master, sharing the single serial memory between the CPU instruction bus (read-only) and data bus (read/write). It registers each granted request and replays it downstream as one classic Wishbone cycle. Before every data-bus byte-enabled write it automatically inserts a FRAM WRITE ENABLE cycle (we=1, sel=0), so firmware never issues WREN itself. It guarantees at least one cyc-low clock between downstream cycles, because the SPI master restarts whenever cyc stays high.

## Interface
- ADDRESS_WIDTH, 24, byte address width of the FRAM; word address ports are [ADDRESS_WIDTH-1:2]
- clock  in  1  system clock; reset reset, asynchronous, active-high; clock clock
- reset  in  1  asynchronous active-high reset
- i_ibus_adr  in  ADDRESS_WIDTH-2  instruction fetch word address
- i_ibus_cyc  in  1  instruction request; held until ack
- o_ibus_rdt  out  32  fetch data, valid with o_ibus_ack
- o_ibus_ack  out  1  single-cycle fetch acknowledge
- i_dbus_adr  in  ADDRESS_WIDTH-2  data word address
- i_dbus_dat  in  32  write data
- i_dbus_sel  in  4  byte enables; 0 = raw status/command cycle
- i_dbus_we  in  1  write strobe
- i_dbus_cyc  in  1  data request; held until ack
- o_dbus_rdt  out  32  read data, valid with o_dbus_ack
- o_dbus_ack  out  1  single-cycle data acknowledge
- o_spi_adr  out  ADDRESS_WIDTH-2  to SPI master address
- o_spi_dat  out  32  to SPI master wr_data
- o_spi_sel  out  4  to SPI master wb_sel
- o_spi_we  out  1  to SPI master wb_we
- o_spi_cyc  out  1  to SPI master wb_cyc
- i_spi_rdt  in  32  from SPI master rd_data
- i_spi_ack  in  1  from SPI master wb_ack

## Operation
- States: IDLE, IBUS, WREN, WGAP, DBUS.
- IDLE: o_spi_cyc=0. The block samples the requests. On a grant it latches adr, dat, sel and we into registers. Downstream outputs are driven only from these registers.
- Grant targets: ibus goes to IBUS with we=0 and sel=4'hF. A dbus request with we=1 and sel!=0 goes to WREN. Any other dbus request goes to DBUS.
- IBUS and DBUS: o_spi_cyc=1 until i_spi_ack. On ack, the matching upstream ack and rdt are driven that cycle, then the state returns to IDLE.
- WREN: o_spi_cyc=1, o_spi_we=1, o_spi_sel=0; latched adr and dat are held. On ack the state goes to WGAP, and no upstream ack is produced.
- WGAP: one cycle with o_spi_cyc=0, then DBUS with the latched write.
- Upstream ack is gated by the requester's cyc. If the requester drops cyc mid-transaction (a protocol violation), the downstream cycle still completes and the ack is discarded.
- A requester may change its inputs while not granted. Latched fields are unaffected.
- last_grant register (0=ibus, 1=dbus) is updated on every grant.

## Timing
- Reset: state=IDLE, last_grant=0, o_spi_cyc=0, o_spi_we=0, o_spi_sel=0, o_spi_adr=0, o_spi_dat=0, o_ibus_ack=0, o_dbus_ack=0, o_ibus_rdt=0, o_dbus_rdt=0.
- Reset asserted mid-cycle: o_spi_cyc drops immediately (asynchronous) and no ack is issued. The SPI master sees cyc low and returns to idle.
- Grant latency: request seen in IDLE at edge N, o_spi_cyc=1 from N+1.
- Ack path: o_*_ack and o_*_rdt are combinational from i_spi_ack and i_spi_rdt in the granted state. Zero added latency.
- Gap: after any downstream ack, o_spi_cyc=0 for at least one full cycle (IDLE or WGAP).
- Write latency = WREN cycle + 1 gap + write cycle. Upstream sees a single ack.
- o_*_rdt is 0 whenever the matching ack is 0.
- Simultaneous ibus and dbus requests in IDLE: resolved per Configuration.

## Configuration
- SERVANT_SPI_ARB_RR_EN defined: round-robin. On a simultaneous request, the port not equal to last_grant wins. A single request is always granted.
- SERVANT_SPI_ARB_RR_EN undefined: fixed priority, dbus always wins. last_grant is still maintained but not used.

## Test plan
- Single fetch: ibus_cyc, adr=0x000100 -> o_spi_cyc=1 next cycle, sel=F, we=0. With i_spi_ack and rdt=0x00000297 -> o_ibus_ack one cycle, o_ibus_rdt=0x00000297.
- Data write: dbus we=1, sel=4'b0011, dat=0xDEADBEEF -> first downstream cycle we=1, sel=0 with no upstream ack. Then at least 1 cyc-low cycle. Then second cycle sel=3, dat=0xDEADBEEF. Exactly one o_dbus_ack.
- Status read: dbus we=0, sel=0 -> one downstream cycle with sel=0 and no WREN; rdt forwarded.
- Contention: both cyc high continuously for 4 transactions -> RR build grants D,I,D,I (dbus first since last_grant=0 after reset). Non-RR build grants dbus until it drops cyc.
- Reset mid-WREN -> o_spi_cyc=0 same cycle, no ack. After release, the pending dbus write restarts from WREN.
- Requester changes i_dbus_dat while granted -> o_spi_dat keeps the latched value.
